// File: rtl/fsmd_game_param.sv
`default_nettype none
// ============================================================================
// Module      : fsmd_game_param
// Description : Parametrised two-player rock-paper-scissors match FSMD.
// Revision    : 1.0 - initial release
// ============================================================================
module fsmd_game_param #(
    parameter int MIN_MANCHE = 4,
    parameter int WIN_MARGIN = 2,
    parameter int CNT_W      = 5,
    parameter int NO_REPEAT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inizia,
    input  logic [1:0]       primo,
    input  logic [1:0]       secondo,
    output logic [1:0]       manche,
    output logic [1:0]       partita,
    output logic [CNT_W-1:0] n_manche,
    output logic             in_gioco
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_END  = 2'd2;

    localparam logic [CNT_W-1:0] C_MIN    = CNT_W'(MIN_MANCHE);
    localparam logic [CNT_W-1:0] C_MARGIN = CNT_W'(WIN_MARGIN);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       r_manche;
    logic [1:0]       r_partita;
    logic [CNT_W-1:0] r_n;
    logic             r_in_gioco;
    logic [CNT_W-1:0] r_w1;
    logic [CNT_W-1:0] r_w2;
    logic [CNT_W-1:0] r_max;
    logic [1:0]       r_last_win;
    logic [1:0]       r_last_move;

    logic             w_p1_wins;
    logic             w_draw;
    logic             w_repeat;
    logic             w_valid;
    logic [1:0]       w_res;
    logic [CNT_W-1:0] w_w1_nx;
    logic [CNT_W-1:0] w_w2_nx;
    logic [CNT_W-1:0] w_n_nx;
    logic [CNT_W-1:0] w_diff;
    logic             w_margin_end;
    logic             w_limit_end;
    logic [1:0]       w_final;

    always_comb begin
        w_p1_wins = ((primo == 2'b10) && (secondo == 2'b01)) ||
                    ((primo == 2'b01) && (secondo == 2'b11)) ||
                    ((primo == 2'b11) && (secondo == 2'b10));
        w_draw    = (primo == secondo);
        // Only the previous winner is restricted; a draw wipes r_last_win.
        w_repeat  = (NO_REPEAT != 0) &&
                    (((r_last_win == 2'b01) && (primo   == r_last_move)) ||
                     ((r_last_win == 2'b10) && (secondo == r_last_move)));
        w_valid   = (primo != 2'b00) && (secondo != 2'b00) && !w_repeat;
        w_res     = w_draw ? 2'b11 : (w_p1_wins ? 2'b01 : 2'b10);
        w_w1_nx   = (w_res == 2'b01) ? r_w1 + C_ONE : r_w1;
        w_w2_nx   = (w_res == 2'b10) ? r_w2 + C_ONE : r_w2;
        w_n_nx    = r_n + C_ONE;
        w_diff    = (w_w1_nx >= w_w2_nx) ? (w_w1_nx - w_w2_nx) : (w_w2_nx - w_w1_nx);
        w_margin_end = (w_n_nx >= C_MIN) && (w_diff >= C_MARGIN);
        w_limit_end  = (w_n_nx == r_max);
        if (w_w1_nx > w_w2_nx)
            w_final = 2'b01;
        else if (w_w2_nx > w_w1_nx)
            w_final = 2'b10;
        else
            w_final = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_manche    <= 2'b00;
            r_partita   <= 2'b00;
            r_n         <= '0;
            r_in_gioco  <= 1'b0;
            r_w1        <= '0;
            r_w2        <= '0;
            r_max       <= C_MIN;
            r_last_win  <= 2'b00;
            r_last_move <= 2'b00;
        end else if (inizia) begin
            r_state     <= S_PLAY;
            r_manche    <= 2'b00;
            r_partita   <= 2'b00;
            r_n         <= '0;
            r_in_gioco  <= 1'b1;
            r_w1        <= '0;
            r_w2        <= '0;
            r_max       <= C_MIN + CNT_W'({primo, secondo});
            r_last_win  <= 2'b00;
            r_last_move <= 2'b00;
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (w_valid) begin
                        r_manche    <= w_res;
                        r_n         <= w_n_nx;
                        r_w1        <= w_w1_nx;
                        r_w2        <= w_w2_nx;
                        r_last_win  <= w_draw ? 2'b00 : w_res;
                        r_last_move <= w_draw ? 2'b00 : (w_p1_wins ? primo : secondo);
                        // Margin end can never tie, so w_final also names the leader.
                        if (w_margin_end || w_limit_end) begin
                            r_partita  <= w_final;
                            r_state    <= S_END;
                            r_in_gioco <= 1'b0;
                        end
                    end else begin
                        r_manche <= 2'b00;
                    end
                end
                S_END: begin
                    r_manche <= 2'b00;
                end
                default: begin
                    r_manche   <= 2'b00;
                    r_partita  <= 2'b00;
                    r_in_gioco <= 1'b0;
                end
            endcase
        end
    end

    assign manche   = r_manche;
    assign partita  = r_partita;
    assign n_manche = r_n;
    assign in_gioco = r_in_gioco;

endmodule
`default_nettype wire

// File: tb/tb_fsmd_game_param.sv
`default_nettype none
// Testbench for fsmd_game_param: default-parameter instance A and a
// MIN_MANCHE=2 / WIN_MARGIN=1 / NO_REPEAT=0 instance B.
module tb_fsmd_game_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       inizia = 1'b0;
    logic [1:0] primo = 2'b00;
    logic [1:0] secondo = 2'b00;

    logic [1:0] a_manche, a_partita, b_manche, b_partita;
    logic [4:0] a_n, b_n;
    logic       a_in, b_in;

    always #5 clk = ~clk;

    fsmd_game_param #(.MIN_MANCHE(4), .WIN_MARGIN(2), .CNT_W(5), .NO_REPEAT(1)) u_a (
        .clk(clk), .rst(rst), .inizia(inizia), .primo(primo), .secondo(secondo),
        .manche(a_manche), .partita(a_partita), .n_manche(a_n), .in_gioco(a_in));

    fsmd_game_param #(.MIN_MANCHE(2), .WIN_MARGIN(1), .CNT_W(5), .NO_REPEAT(0)) u_b (
        .clk(clk), .rst(rst), .inizia(inizia), .primo(primo), .secondo(secondo),
        .manche(b_manche), .partita(b_partita), .n_manche(b_n), .in_gioco(b_in));

    typedef struct {
        logic       sel;
        logic       rst;
        logic       ini;
        logic [1:0] p;
        logic [1:0] s;
        logic [1:0] em;
        logic [1:0] ep;
        logic [4:0] en;
        logic       ei;
    } vec_t;

    vec_t tv[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(input logic sel, input logic r, input logic ini,
                                input logic [1:0] p, input logic [1:0] s,
                                input logic [1:0] em, input logic [1:0] ep,
                                input int en, input logic ei);
        vec_t v;
        v.sel = sel; v.rst = r; v.ini = ini; v.p = p; v.s = s;
        v.em = em; v.ep = ep; v.en = 5'(en); v.ei = ei;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int expv);
        n_checks++;
        if (act == expv)
            n_pass++;
        else
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, expv);
    endtask

    task automatic step(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        rst = v.rst; inizia = v.ini; primo = v.p; secondo = v.s;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.sel == 1'b0) begin
            chk("manche_a",   idx, int'(a_manche),  int'(e.em));
            chk("partita_a",  idx, int'(a_partita), int'(e.ep));
            chk("n_manche_a", idx, int'(a_n),       int'(e.en));
            chk("in_gioco_a", idx, int'(a_in),      int'(e.ei));
        end else begin
            chk("manche_b",   idx, int'(b_manche),  int'(e.em));
            chk("partita_b",  idx, int'(b_partita), int'(e.ep));
            chk("n_manche_b", idx, int'(b_n),       int'(e.en));
            chk("in_gioco_b", idx, int'(b_in),      int'(e.ei));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //                 sel rst ini p      s      manche partita n  in
        // reset and moves ignored in IDLE
        tv.push_back(mk(0, 1, 0, 2'b01, 2'b11, 2'b00, 2'b00, 0, 0));
        tv.push_back(mk(0, 0, 0, 2'b01, 2'b11, 2'b00, 2'b00, 0, 0));
        // basic match, margin end for P1 (max 4)
        tv.push_back(mk(0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
        tv.push_back(mk(0, 0, 0, 2'b01, 2'b11, 2'b01, 2'b00, 1, 1));
        tv.push_back(mk(0, 0, 0, 2'b10, 2'b01, 2'b01, 2'b00, 2, 1));
        tv.push_back(mk(0, 0, 0, 2'b11, 2'b10, 2'b01, 2'b00, 3, 1));
        tv.push_back(mk(0, 0, 0, 2'b10, 2'b11, 2'b10, 2'b01, 4, 0));
        tv.push_back(mk(0, 0, 0, 2'b01, 2'b11, 2'b00, 2'b01, 4, 0));
        tv.push_back(mk(0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b01, 4, 0));
        // no-repeat rule, invalid move, draw clears history
        tv.push_back(mk(0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
        tv.push_back(mk(0, 0, 0, 2'b01, 2'b11, 2'b01, 2'b00, 1, 1));
        tv.push_back(mk(0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 1, 1));
        tv.push_back(mk(0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, 1, 1));
        tv.push_back(mk(0, 0, 0, 2'b10, 2'b10, 2'b11, 2'b00, 2, 1));
        tv.push_back(mk(0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00, 3, 1));
        tv.push_back(mk(0, 0, 0, 2'b11, 2'b10, 2'b00, 2'b00, 3, 1));
        // limit end with max 5, ending 2-2 -> draw
        tv.push_back(mk(0, 0, 1, 2'b00, 2'b01, 2'b00, 2'b00, 0, 1));
        tv.push_back(mk(0, 0, 0, 2'b01, 2'b11, 2'b01, 2'b00, 1, 1));
        tv.push_back(mk(0, 0, 0, 2'b11, 2'b01, 2'b10, 2'b00, 2, 1));
        tv.push_back(mk(0, 0, 0, 2'b01, 2'b11, 2'b01, 2'b00, 3, 1));
        tv.push_back(mk(0, 0, 0, 2'b11, 2'b01, 2'b10, 2'b00, 4, 1));
        tv.push_back(mk(0, 0, 0, 2'b10, 2'b10, 2'b11, 2'b11, 5, 0));
        tv.push_back(mk(0, 0, 0, 2'b01, 2'b11, 2'b00, 2'b11, 5, 0));
        // mid-match restart clears counters and history
        tv.push_back(mk(0, 0, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0, 1));
        tv.push_back(mk(0, 0, 0, 2'b01, 2'b11, 2'b01, 2'b00, 1, 1));
        tv.push_back(mk(0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
        tv.push_back(mk(0, 0, 0, 2'b01, 2'b11, 2'b01, 2'b00, 1, 1));
        // rst mid-PLAY, then rst wins over inizia
        tv.push_back(mk(0, 1, 0, 2'b01, 2'b11, 2'b00, 2'b00, 0, 0));
        tv.push_back(mk(0, 0, 0, 2'b01, 2'b11, 2'b00, 2'b00, 0, 0));
        tv.push_back(mk(0, 1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0, 0));
        tv.push_back(mk(0, 0, 0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0));
        // margin end for P2
        tv.push_back(mk(0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1));
        tv.push_back(mk(0, 0, 0, 2'b11, 2'b01, 2'b10, 2'b00, 1, 1));
        tv.push_back(mk(0, 0, 0, 2'b10, 2'b11, 2'b10, 2'b00, 2, 1));
        tv.push_back(mk(0, 0, 0, 2'b10, 2'b01, 2'b01, 2'b00, 3, 1));
        tv.push_back(mk(0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b10, 4, 0));

        for (int i = 0; i < tv.size(); i++)
            step(tv[i], i);

        // Instance B: repeat allowed, then margin 1 after round 2
        step(mk(1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0), 100);
        step(mk(1, 0, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0, 1), 101);
        step(mk(1, 0, 0, 2'b01, 2'b11, 2'b01, 2'b00, 1, 1), 102);
        step(mk(1, 0, 0, 2'b01, 2'b10, 2'b10, 2'b00, 2, 1), 103);
        step(mk(1, 0, 0, 2'b01, 2'b11, 2'b01, 2'b01, 3, 0), 104);
        step(mk(1, 0, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0, 1), 105);
        step(mk(1, 0, 0, 2'b01, 2'b11, 2'b01, 2'b00, 1, 1), 106);
        step(mk(1, 0, 0, 2'b01, 2'b11, 2'b01, 2'b01, 2, 0), 107);
        step(mk(1, 0, 0, 2'b10, 2'b01, 2'b00, 2'b01, 2, 0), 108);
        // limit end at max=2 with tied counts
        step(mk(1, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1), 109);
        step(mk(1, 0, 0, 2'b10, 2'b10, 2'b11, 2'b00, 1, 1), 110);
        step(mk(1, 0, 0, 2'b11, 2'b11, 2'b11, 2'b11, 2, 0), 111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
